// File: rtl/fetch_rf_wr_ctrl_pkg.sv
// Shared constants and helpers for the fetch line-buffer write path.
package fetch_rf_wr_ctrl_pkg;

    localparam int unsigned PIXEL_WIDTH    = 8;
    localparam int unsigned FETCH_ROW_PIX  = 64;
    localparam int unsigned FETCH_BEAT_PIX = 8;
    localparam int unsigned FETCH_RF_AW    = 7;

    // Row address relative to a base, wrapping at the buffer depth.
    function automatic logic [FETCH_RF_AW-1:0] rf_row_addr(
        input logic [FETCH_RF_AW-1:0] base,
        input logic [FETCH_RF_AW:0]   row
    );
        return base + row[FETCH_RF_AW-1:0];
    endfunction

endpackage

// File: rtl/fetch_rf_row_pack.sv
// Packs consecutive input beats into one buffer row; beat 0 lands in the LSBs.
module fetch_rf_row_pack
    import fetch_rf_wr_ctrl_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = fetch_rf_wr_ctrl_pkg::PIXEL_WIDTH,
    parameter int unsigned BEAT_PIX    = FETCH_BEAT_PIX,
    parameter int unsigned ROW_PIX     = FETCH_ROW_PIX
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            beat_en,
    input  logic [BEAT_PIX*PIXEL_WIDTH-1:0] beat_data,
    output logic [ROW_PIX*PIXEL_WIDTH-1:0]  row_data,
    output logic                            row_full
);

    localparam int unsigned BEAT_W = BEAT_PIX * PIXEL_WIDTH;
    localparam int unsigned BEATS  = ROW_PIX / BEAT_PIX;
    localparam int unsigned CNT_W  = $clog2(BEATS);

    logic [CNT_W-1:0] beat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            row_data   <= '0;
        end else if (clear) begin
            beat_cnt_q <= '0;
        end else if (beat_en) begin
            row_data[beat_cnt_q * BEAT_W +: BEAT_W] <= beat_data;
            beat_cnt_q <= beat_cnt_q + 1'b1;
        end
    end

    // Combinational so the FSM leaves LOAD on the same edge the last beat lands.
    assign row_full = beat_en && (beat_cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/fetch_rf_wr_ctrl.sv
// Write-side controller for the fetch line buffer: packs beats into rows and
// writes them at consecutive addresses, yielding the port to the reader.
module fetch_rf_wr_ctrl
    import fetch_rf_wr_ctrl_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = fetch_rf_wr_ctrl_pkg::PIXEL_WIDTH,
    parameter int unsigned BEAT_PIX    = FETCH_BEAT_PIX,
    parameter int unsigned ROW_PIX     = FETCH_ROW_PIX,
    parameter int unsigned ADDR_W      = FETCH_RF_AW
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [ADDR_W-1:0]               base_addr_i,
    input  logic [ADDR_W:0]                 row_num_i,
    input  logic                            data_valid_i,
    input  logic [BEAT_PIX*PIXEL_WIDTH-1:0] data_i,
    output logic                            data_ready_o,
    input  logic                            rd_req_i,
    output logic                            wrif_en_o,
    output logic [ADDR_W-1:0]               wrif_addr_o,
    output logic [ROW_PIX*PIXEL_WIDTH-1:0]  wrif_data_o,
    output logic                            busy_o,
    output logic                            done_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_t;

    state_t                         state_q;
    logic [ADDR_W-1:0]              base_q;
    logic [ADDR_W:0]                row_num_q;
    logic [ADDR_W:0]                row_cnt_q;
    logic [ROW_PIX*PIXEL_WIDTH-1:0] row_data;
    logic                           row_full;
    logic                           beat_en;
    logic                           start_ok;

    assign beat_en  = data_valid_i && data_ready_o;
    // done_o high means the previous load is still being reported; drop starts.
    assign start_ok = start_i && (state_q == StIdle) && !done_o;

    fetch_rf_row_pack #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .BEAT_PIX    (BEAT_PIX),
        .ROW_PIX     (ROW_PIX)
    ) u_row_pack (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .beat_en   (beat_en),
        .beat_data (data_i),
        .row_data  (row_data),
        .row_full  (row_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            base_q       <= '0;
            row_num_q    <= '0;
            row_cnt_q    <= '0;
            data_ready_o <= 1'b0;
            wrif_en_o    <= 1'b0;
            wrif_addr_o  <= '0;
            wrif_data_o  <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            wrif_en_o <= 1'b0;
            done_o    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        base_q    <= base_addr_i;
                        row_num_q <= row_num_i;
                        row_cnt_q <= '0;
                        if (row_num_i == '0) begin
                            state_q <= StDone;
                        end else begin
                            state_q      <= StLoad;
                            data_ready_o <= 1'b1;
                            busy_o       <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (row_full) begin
                        state_q      <= StWrite;
                        data_ready_o <= 1'b0;
                    end
                end
                StWrite: begin
                    // The reader owns the port this cycle; hold the row and retry.
                    if (!rd_req_i) begin
                        wrif_en_o   <= 1'b1;
                        wrif_addr_o <= rf_row_addr(base_q, row_cnt_q);
                        wrif_data_o <= row_data;
                        row_cnt_q   <= row_cnt_q + 1'b1;
                        if ((row_cnt_q + 1'b1) == row_num_q) begin
                            state_q <= StDone;
                            busy_o  <= 1'b0;
                        end else begin
                            state_q      <= StLoad;
                            data_ready_o <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    done_o  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_rf_wr_ctrl.sv
// Directed self-checking bench for fetch_rf_wr_ctrl.
module tb_fetch_rf_wr_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [6:0]   base_addr_i;
    logic [7:0]   row_num_i;
    logic         data_valid_i;
    logic [63:0]  data_i;
    logic         data_ready_o;
    logic         rd_req_i;
    logic         wrif_en_o;
    logic [6:0]   wrif_addr_o;
    logic [511:0] wrif_data_o;
    logic         busy_o;
    logic         done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cyc_last = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    logic [6:0]   wr_addr_q[$];
    logic [511:0] wr_data_q[$];

    always #5 clk = ~clk;

    fetch_rf_wr_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .row_num_i    (row_num_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .rd_req_i     (rd_req_i),
        .wrif_en_o    (wrif_en_o),
        .wrif_addr_o  (wrif_addr_o),
        .wrif_data_o  (wrif_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wrif_en_o) begin
            wr_addr_q.push_back(wrif_addr_o);
            wr_data_q.push_back(wrif_data_o);
            wr_cyc_last = cyc;
        end
        if (done_o) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_beat(input int seed, input int row, input int k);
        logic [63:0] b;
        for (int j = 0; j < 8; j++) b[8*j +: 8] = 8'(seed + row * 67 + k * 8 + j);
        return b;
    endfunction

    function automatic logic [511:0] mk_row(input int seed, input int row);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[64*k +: 64] = mk_beat(seed, row, k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [6:0] base, input logic [7:0] rows);
        start_i     = 1'b1;
        base_addr_i = base;
        row_num_i   = rows;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d);
        bit acc = 1'b0;
        data_valid_i = 1'b1;
        data_i       = d;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = data_ready_o;
            tick();
        end
        data_valid_i = 1'b0;
        if (!acc) check_eq("beat_accept_timeout", acc, 1);
    endtask

    task automatic send_rows(input int seed, input int first, input int n, input bit gaps);
        for (int r = first; r < first + n; r++) begin
            for (int k = 0; k < 8; k++) begin
                send_beat(mk_beat(seed, r, k));
                if (gaps) tick();
            end
        end
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done_o) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        check_eq($sformatf("%s_done", tag), seen, 1);
        tick();
        @(negedge clk);
        check_eq($sformatf("%s_busy_after", tag), busy_o, 0);
        tick();
    endtask

    task automatic check_writes(input string tag, input int seed, input logic [6:0] base,
                                input int n);
        int m;
        check_eq($sformatf("%s_wr_count", tag), wr_addr_q.size(), n);
        m = (wr_addr_q.size() < n) ? wr_addr_q.size() : n;
        for (int i = 0; i < m; i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], 7'(base + i));
            check_eq($sformatf("%s_data%0d", tag, i), wr_data_q[i], mk_row(seed, i));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] exp1;
        logic [127:0] cover_map;

        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; row_num_i = '0;
        data_valid_i = 1'b0; data_i = '0; rd_req_i = 1'b0;
        tick(); tick();
        @(negedge clk);
        check_eq("rst_wrif_en", wrif_en_o, 0);
        check_eq("rst_ready", data_ready_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_addr", wrif_addr_o, 0);
        check_eq("rst_data", wrif_data_o, 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single row, beat k = byte k repeated
        clear_log();
        exp1 = {{8{8'h07}}, {8{8'h06}}, {8{8'h05}}, {8{8'h04}},
                {8{8'h03}}, {8{8'h02}}, {8{8'h01}}, {8{8'h00}}};
        do_start(7'd5, 8'd1);
        for (int k = 0; k < 8; k++) send_beat({8{8'(k)}});
        wait_done("t1", 50);
        check_eq("t1_wr_count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0) begin
            check_eq("t1_addr", wr_addr_q[0], 7'd5);
            check_eq("t1_data", wr_data_q[0], exp1);
        end
        check_eq("t1_done_after_write", done_cyc, wr_cyc_last + 1);

        // 2: address wrap
        clear_log();
        do_start(7'd120, 8'd16);
        send_rows(3, 0, 16, 1'b0);
        wait_done("t2", 50);
        check_writes("t2", 3, 7'd120, 16);
        check_eq("t2_last_addr", (wr_addr_q.size() == 16) ? wr_addr_q[15] : 7'h7f, 7'd7);
        check_eq("t2_done_cnt", done_cnt, 1);

        // 3: reader holds the port when the first row completes
        clear_log();
        do_start(7'd10, 8'd2);
        send_rows(5, 0, 1, 1'b0);
        rd_req_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("t3_hold_en%0d", i), wrif_en_o, 0);
            check_eq($sformatf("t3_hold_ready%0d", i), data_ready_o, 0);
            tick();
        end
        rd_req_i = 1'b0;
        @(negedge clk);
        check_eq("t3_hold_en5", wrif_en_o, 0);
        tick();
        @(negedge clk);
        check_eq("t3_write_fires", wrif_en_o, 1);
        check_eq("t3_write_addr", wrif_addr_o, 7'd10);
        check_eq("t3_write_data", wrif_data_o, mk_row(5, 0));
        tick();
        send_rows(5, 1, 1, 1'b0);
        wait_done("t3", 50);
        check_writes("t3", 5, 7'd10, 2);

        // 4: valid toggling every cycle
        clear_log();
        do_start(7'd40, 8'd3);
        send_rows(7, 0, 3, 1'b1);
        wait_done("t4", 50);
        check_writes("t4", 7, 7'd40, 3);

        // 5: reset after 5 beats of the second row
        clear_log();
        do_start(7'd60, 8'd4);
        send_rows(9, 0, 1, 1'b0);
        for (int k = 0; k < 5; k++) send_beat(mk_beat(9, 1, k));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_rst_en", wrif_en_o, 0);
        check_eq("t5_rst_ready", data_ready_o, 0);
        check_eq("t5_rst_busy", busy_o, 0);
        check_eq("t5_rst_done", done_o, 0);
        check_eq("t5_rst_addr", wrif_addr_o, 0);
        check_eq("t5_rst_data", wrif_data_o, 0);
        tick();
        clear_log();
        for (int i = 0; i < 20; i++) tick();
        check_eq("t5_no_writes", wr_addr_q.size(), 0);
        do_start(7'd90, 8'd1);
        send_rows(11, 0, 1, 1'b0);
        wait_done("t5", 50);
        check_writes("t5", 11, 7'd90, 1);

        // 6a: zero rows
        clear_log();
        do_start(7'd3, 8'd0);
        wait_done("t6a", 20);
        check_eq("t6a_wr_count", wr_addr_q.size(), 0);

        // 6b: all 128 rows, with a start pulse while busy
        clear_log();
        do_start(7'd33, 8'd128);
        send_rows(13, 0, 1, 1'b0);
        do_start(7'd0, 8'd1);
        send_rows(13, 1, 127, 1'b0);
        wait_done("t6b", 50);
        check_writes("t6b", 13, 7'd33, 128);
        cover_map = '0;
        foreach (wr_addr_q[i]) cover_map[wr_addr_q[i]] = 1'b1;
        check_eq("t6b_cover", cover_map, {128{1'b1}});
        check_eq("t6b_done_cnt", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
